// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, widths and helpers for the PLL reset sequencer.
package pll_seq_pkg;
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int STAT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/sync_ff2.sv
// sync_ff2: two-flop synchronizer for a single asynchronous bit, async active-low reset to 0.
module sync_ff2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
endmodule

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: sequences PLL reset and releases user reset once lock has been stable.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 24000,
    parameter int STABLE_CYCLES  = 2400,
    parameter int CNT_W          = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pll_lock,
    input  logic              sw_restart,
    output logic              pll_reset,
    output logic              user_rst_n,
    output logic              ready,
    output logic [STAT_W-1:0] lock_lost_cnt,
    output logic [STAT_W-1:0] timeout_cnt
);
    // The counter clears to 0 and counts down, so N elapsed cycles reads as -N.
    localparam logic [CNT_W-1:0] RST_END = CNT_W'(-(PLL_RST_CYCLES - 1));
    localparam logic [CNT_W-1:0] TMO_END = CNT_W'(-(LOCK_TIMEOUT - 1));
    localparam logic [CNT_W-1:0] STB_END = CNT_W'(-(STABLE_CYCLES - 1));

    pll_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             lock_s, lost_inc, tmo_inc, pll_reset_next, run_next;

    sync_ff2 u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) state <= RESET_PLL;
        else            state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            RESET_PLL: state_next = (cnt == RST_END) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: state_next = lock_s ? STABLE : (cnt == TMO_END) ? RESET_PLL : WAIT_LOCK;
            STABLE:    state_next = !lock_s ? WAIT_LOCK : (cnt == STB_END) ? RUN : STABLE;
            RUN:       state_next = lock_s ? RUN : WAIT_LOCK;
            default:   state_next = RESET_PLL;
        endcase
        if (sw_restart) state_next = RESET_PLL;
    end

    always_comb begin
        pll_reset_next = (state_next == RESET_PLL);
        run_next       = (state_next == RUN);
        tmo_inc        = !sw_restart && state == WAIT_LOCK && !lock_s && cnt == TMO_END;
        lost_inc       = !sw_restart && state == RUN && !lock_s;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            cnt           <= '0;
            pll_reset     <= 1'b1;
            user_rst_n    <= 1'b0;
            ready         <= 1'b0;
            lock_lost_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            cnt        <= (sw_restart || state_next != state) ? '0 : cnt - CNT_W'(1);
            pll_reset  <= pll_reset_next;
            user_rst_n <= run_next;
            ready      <= run_next;
            if (lost_inc && lock_lost_cnt != '1) lock_lost_cnt <= lock_lost_cnt + STAT_W'(1);
            if (tmo_inc && timeout_cnt != '1) timeout_cnt <= timeout_cnt + STAT_W'(1);
        end
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: directed and randomized checks of the PLL reset sequencer against a behavioural model.
module tb_pll_lock_reset_seq;
    localparam int P = 4;
    localparam int T = 20;
    localparam int S = 8;

    logic       sys_clk, sys_rst_n, pll_lock, sw_restart;
    logic       pll_reset, user_rst_n, ready;
    logic [7:0] lock_lost_cnt, timeout_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_reset_seq #(.PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .pll_lock      (pll_lock),
        .sw_restart    (sw_restart),
        .pll_reset     (pll_reset),
        .user_rst_n    (user_rst_n),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 PLL reset, 1 waiting for lock, 2 lock qualifying, 3 running.
    int m_phase, m_elapsed, m_lost, m_tmo;
    bit m_sync[2];

    function automatic void model_reset();
        m_phase = 0; m_elapsed = 0; m_lost = 0; m_tmo = 0;
        m_sync[0] = 0; m_sync[1] = 0;
    endfunction

    function automatic void model_enter(input int ph);
        m_phase = ph; m_elapsed = 0;
    endfunction

    function automatic void model_step(input bit lk, input bit rs);
        bit seen = m_sync[1];
        m_sync[1] = m_sync[0];
        m_sync[0] = lk;
        if (rs) model_enter(0);
        else if (m_phase == 0) begin
            if (m_elapsed == P - 1) model_enter(1); else m_elapsed++;
        end else if (m_phase == 1) begin
            if (seen) model_enter(2);
            else if (m_elapsed == T - 1) begin model_enter(0); m_tmo = (m_tmo < 255) ? m_tmo + 1 : 255; end
            else m_elapsed++;
        end else if (m_phase == 2) begin
            if (!seen) model_enter(1);
            else if (m_elapsed == S - 1) model_enter(3);
            else m_elapsed++;
        end else if (!seen) begin
            model_enter(1);
            m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        end
    endfunction

    task automatic cycle(input logic lk, input logic rs);
        pll_lock = lk; sw_restart = rs;
        @(posedge sys_clk);
        model_step(lk, rs);
        #1;
        check("m_pll_reset", pll_reset, (m_phase == 0));
        check("m_user_rst_n", user_rst_n, (m_phase == 3));
        check("m_ready", ready, (m_phase == 3));
        check("m_lock_lost", lock_lost_cnt, m_lost);
        check("m_timeout", timeout_cnt, m_tmo);
    endtask

    task automatic apply_reset();
        sw_restart = 1'b0;
        #3 sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pll_reset", pll_reset, 1);
        check("rst_user_rst_n", user_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_lock_lost", lock_lost_cnt, 0);
        check("rst_timeout", timeout_cnt, 0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    initial begin
        int n, k, prev, saw;
        sys_rst_n = 1'b0; pll_lock = 1'b0; sw_restart = 1'b0;
        model_reset();
        @(posedge sys_clk);
        #1;
        // Power-up, lock rises 10 cycles after release.
        apply_reset();
        n = 0;
        do begin cycle(0, 0); n++; end while (pll_reset && n < 50);
        check("pwrup_rst_len", n, P);
        repeat (10 - n) cycle(0, 0);
        n = 0;
        do begin cycle(1, 0); n++; end while (!user_rst_n && n < 100);
        check("pwrup_release_lat", n, 2 + S + 1);
        check("pwrup_ready", ready, 1);
        check("pwrup_stats", {lock_lost_cnt, timeout_cnt}, 0);
        // Lock never asserts.
        apply_reset();
        prev = 1; k = 0;
        for (int e = 1; e <= 75; e++) begin
            cycle(0, 0);
            if (pll_reset && !prev) begin
                k++;
                check("tmo_period", e, (P + T) * k);
                check("tmo_cnt", timeout_cnt, k);
            end
            prev = pll_reset;
        end
        check("tmo_pulses", k, 3);
        // Lock drops for 5 cycles in RUN.
        apply_reset();
        repeat (20) cycle(1, 0);
        check("run_ready", ready, 1);
        n = 0;
        do begin cycle(0, 0); n++; end while (user_rst_n && n < 20);
        check("drop_lat", n, 3);
        check("drop_lost", lock_lost_cnt, 1);
        repeat (2) cycle(0, 0);
        saw = 0; n = 0;
        do begin cycle(1, 0); n++; saw |= pll_reset; end while (!user_rst_n && n < 100);
        check("relock_lat", n, 11);
        check("relock_no_pll_rst", saw, 0);
        // Two-cycle glitch while qualifying lock.
        apply_reset();
        repeat (6) cycle(1, 0);
        repeat (2) cycle(0, 0);
        n = 8;
        do begin cycle(1, 0); n++; end while (!user_rst_n && n < 100);
        check("glitch_release_edge", n, 19);
        check("glitch_lost", lock_lost_cnt, 0);
        // Restart coincident with a RUN lock drop.
        apply_reset();
        repeat (20) cycle(1, 0);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 1);
        check("swr_pll_reset", pll_reset, 1);
        check("swr_user_rst_n", user_rst_n, 0);
        check("swr_lost", lock_lost_cnt, 0);
        // Saturation, then async reset mid-qualification.
        apply_reset();
        repeat (20) cycle(1, 0);
        for (int i = 0; i < 300; i++) begin
            n = 0;
            do begin cycle(0, 0); n++; end while (user_rst_n && n < 10);
            n = 0;
            do begin cycle(1, 0); n++; end while (!user_rst_n && n < 40);
        end
        check("sat_lost", lock_lost_cnt, 255);
        repeat (3) cycle(0, 0);
        repeat (4) cycle(1, 0);
        check("stable_not_ready", ready, 0);
        apply_reset();
        // Randomized traffic.
        for (int i = 0; i < 3000;) begin
            int dur = $urandom_range(1, 30);
            logic lk = 1'($urandom_range(0, 1));
            repeat (dur) begin
                cycle(lk, 1'($urandom_range(0, 63) == 0));
                i++;
            end
            if ($urandom_range(0, 40) == 0) apply_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
